// File: rtl/rcnot_pipe.sv
// rcnot_pipe: reversible-gate datapath (PASS / CNOT fan-out / Toffoli / Fredkin)
// feeding a two-entry output skid buffer, plus a saturating count of
// accepted non-PASS operations.
//
// Handshake: a word moves on any rising edge where valid && ready are both
// high on that interface. A producer may not withdraw or change an offered
// word until it is taken. The consumer sees out_data/out_valid held stable
// while out_valid && !out_ready. in_ready depends only on registered state,
// so there is no combinational path from out_ready to in_ready.
module rcnot_pipe #(
  parameter int WIDTH = 4,
  parameter int NCTRL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_clr,
  output logic [15:0]      op_count,
  output logic [1:0]       dbg_state
);

  // Targets are the bits above the controls; Fredkin swaps the lower half
  // of the targets with the upper half, leaving an odd top bit alone.
  localparam int NTGT  = WIDTH - NCTRL;
  localparam int HALF  = NTGT / 2;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_CNOT = 2'b01;
  localparam logic [1:0] OP_TOFF = 2'b10;
  localparam logic [1:0] OP_FRED = 2'b11;

  // Occupancy of the output buffer; the head entry is always head_q.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             ctrl_all;
  logic [WIDTH-1:0] gate_res;
  logic             accept;
  logic             drain;

  // Ready and valid are decoded purely from the state register.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = head_q;
  assign op_count  = cnt_q;
  assign dbg_state = state_q;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  assign ctrl_all = &in_data[NCTRL-1:0];

  // Gate evaluation on the offered word; controls always pass through.
  always_comb begin
    gate_res = in_data;
    case (in_op)
      OP_CNOT: begin
        for (int i = NCTRL; i < WIDTH; i++) begin
          gate_res[i] = in_data[i] ^ in_data[0];
        end
      end
      OP_TOFF: begin
        for (int i = NCTRL; i < WIDTH; i++) begin
          gate_res[i] = in_data[i] ^ ctrl_all;
        end
      end
      OP_FRED: begin
        if (ctrl_all) begin
          for (int k = 0; k < HALF; k++) begin
            gate_res[NCTRL+k]      = in_data[NCTRL+HALF+k];
            gate_res[NCTRL+HALF+k] = in_data[NCTRL+k];
          end
        end
      end
      default: gate_res = in_data;
    endcase
  end

  // Buffer next-state: accept grows occupancy, drain shrinks it, both hold it.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = gate_res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          head_d  = gate_res;
        end else if (accept) begin
          tail_d  = gate_res;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Operation counter: clear wins over a same-cycle increment; saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = 16'd0;
    end else if (accept && (in_op != OP_PASS) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State, buffer entries and counter registers; reset discards everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rcnot_pipe.sv
// Testbench for rcnot_pipe: an 8-bit/2-control instance under directed and
// random traffic checked by a negedge scoreboard, plus a 4-bit/1-control
// instance for the small CNOT case.
module tb_rcnot_pipe;

  localparam int W  = 8;
  localparam int NC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   in_op, dbg_state;
  logic [15:0]  op_count;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr;
  logic [3:0]   s_in_data, s_out_data;
  logic [1:0]   s_in_op, s_dbg_state;
  logic [15:0]  s_op_count;

  rcnot_pipe #(.WIDTH(W), .NCTRL(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .op_count(op_count), .dbg_state(dbg_state)
  );

  rcnot_pipe #(.WIDTH(4), .NCTRL(1)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_op(s_in_op),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .cnt_clr(s_cnt_clr), .op_count(s_op_count), .dbg_state(s_dbg_state)
  );

  // ---------------- counters / scoreboard state ----------------
  int           tests_run = 0;
  int           fails     = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt   = 16'd0;
  bit           mon_en    = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  // Reference gate built from masks and shifts on the whole word.
  function automatic logic [31:0] ref_gate(input logic [31:0] d, input logic [1:0] op,
                                           input int w, input int nc);
    logic [31:0] cmask, tmask, hmask, fmask, lo, hi;
    logic        all_c;
    int          h;
    cmask = (32'd1 << nc) - 32'd1;
    tmask = ((32'd1 << w) - 32'd1) & ~cmask;
    all_c = ((d & cmask) == cmask);
    h     = (w - nc) / 2;
    hmask = (32'd1 << h) - 32'd1;
    fmask = ((32'd1 << (2 * h)) - 32'd1) << nc;
    lo    = (d >> nc) & hmask;
    hi    = (d >> (nc + h)) & hmask;
    case (op)
      2'd1:    return d[0] ? (d ^ tmask) : d;
      2'd2:    return all_c ? (d ^ tmask) : d;
      2'd3:    return all_c ? ((d & ~fmask) | (lo << (nc + h)) | (hi << nc)) : d;
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard (samples on the falling edge) ----------------
  always @(negedge clk) begin
    logic [31:0] r;
    bit          acc;
    if (mon_en) begin
      check("out_valid_vs_model", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("in_ready_vs_model",  {31'd0, in_ready},  {31'd0, exp_q.size() < 2});
      check("op_count_vs_model",  {16'd0, op_count},  {16'd0, exp_cnt});
      if (prev_stall) begin
        check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        check("stall_data_hold",  {24'd0, out_data},  {24'd0, prev_data});
      end
      if (!rst_n) begin
        exp_q.delete();
        exp_cnt    = 16'd0;
        prev_stall = 1'b0;
      end else begin
        acc = in_valid && (exp_q.size() < 2);
        if (out_valid && out_ready && exp_q.size() > 0) begin
          check("fifo_data", {24'd0, out_data}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
        if (acc) begin
          r = ref_gate({24'd0, in_data}, in_op, W, NC);
          exp_q.push_back(r[W-1:0]);
        end
        if (cnt_clr) exp_cnt = 16'd0;
        else if (acc && in_op != 2'd0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] op);
    in_valid = v;
    in_data  = d;
    in_op    = op;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 2'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] d, r1;
    logic [31:0]  m;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = 2'd0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_op = 2'd0; s_out_ready = 1'b1; s_cnt_clr = 1'b0;

    // reset state after the first edge with rst_n low
    @(posedge clk); #1;
    mon_en = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_op_count",  {16'd0, op_count},  32'd0);
    check("rst_small_valid", {31'd0, s_out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 4-bit CNOT: 1011 -> 0101 one cycle after the handshake
    s_in_valid = 1'b1; s_in_data = 4'b1011; s_in_op = 2'd1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("small_cnot_valid", {31'd0, s_out_valid}, 32'd1);
    check("small_cnot_data",  {28'd0, s_out_data},  {28'd0, 4'b0101});
    check("small_op_count",   {16'd0, s_op_count},  32'd1);

    // 8-bit/2-control directed vectors
    drive(1'b1, 8'hA7, 2'd2);
    check("toff_a7", {24'd0, out_data}, 32'h5B);
    drive(1'b1, 8'hA6, 2'd2);
    check("toff_a6", {24'd0, out_data}, 32'hA6);
    drive(1'b1, 8'b1011_0011, 2'd3);
    check("fred_b3", {24'd0, out_data}, 32'h97);
    idle(2);

    // back-pressure: two words fill the buffer, the third is refused
    out_ready = 1'b0;
    drive(1'b1, 8'h5A, 2'd1);
    drive(1'b1, 8'hC3, 2'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 8'h0F, 2'd3);
    in_valid = 1'b0;
    m = ref_gate(32'h5A, 2'd1, W, NC);
    check("bp_head", {24'd0, out_data}, m);
    out_ready = 1'b1;
    idle(3);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    end
    out_ready = 1'b1;
    idle(3);

    // loop-back: each op applied twice restores the original word
    for (int op = 0; op < 4; op++) begin
      for (int j = 0; j < 6; j++) begin
        d = W'($urandom_range(0, 255));
        drive(1'b1, d, 2'(op));
        r1 = out_data;
        drive(1'b1, r1, 2'(op));
        check("loopback", {24'd0, out_data}, {24'd0, d});
        idle(1);
      end
    end

    // counter saturation and clear priority
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    check("cnt_cleared", {16'd0, op_count}, 32'd0);
    for (int i = 0; i < 65534; i++) drive(1'b1, W'($urandom_range(0, 255)), 2'd1);
    check("cnt_fffe", {16'd0, op_count}, 32'hFFFE);
    for (int i = 0; i < 3; i++) drive(1'b1, W'($urandom_range(0, 255)), 2'd1);
    check("cnt_saturated", {16'd0, op_count}, 32'hFFFF);
    cnt_clr = 1'b1;
    drive(1'b1, W'($urandom_range(0, 255)), 2'd2);
    cnt_clr = 1'b0;
    check("cnt_clr_wins", {16'd0, op_count}, 32'd0);
    drive(1'b1, W'($urandom_range(0, 255)), 2'd3);
    check("cnt_after_clr", {16'd0, op_count}, 32'd1);
    drive(1'b1, W'($urandom_range(0, 255)), 2'd0);
    check("cnt_pass_ignored", {16'd0, op_count}, 32'd1);
    idle(2);

    // reset with both entries occupied
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 2'd1);
    drive(1'b1, 8'h22, 2'd2);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    drive(1'b1, 8'h33, 2'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_op_count",  {16'd0, op_count},  32'd0);
    check("midrst_out_data",  {24'd0, out_data},  32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
    check("no_stale_word", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 8'h3C, 2'd0);
    check("post_rst_pass", {24'd0, out_data}, 32'h3C);
    idle(2);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
